// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_uart_tx: pops words from a sync FIFO and sends them as UART      |
// | frames (start, data LSB-first, optional parity, stop bits).           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [c_BAUD_W-1:0] c_LAST_BAUD = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_BIT  = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_LATCH  = 3'd2;
    localparam logic [2:0] c_START  = 3'd3;
    localparam logic [2:0] c_DATA   = 3'd4;
    localparam logic [2:0] c_PARITY = 3'd5;
    localparam logic [2:0] c_STOP   = 3'd6;

    logic [2:0]            r_state;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;

    logic w_in_bit;
    logic w_bit_end;

    assign w_in_bit  = (r_state == c_START) || (r_state == c_DATA) ||
                       (r_state == c_PARITY) || (r_state == c_STOP);
    assign w_bit_end = (r_baud == c_LAST_BAUD);
    assign busy      = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            tx         <= 1'b1;
            fifo_r_en  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_r_en  <= 1'b0;
            frame_done <= 1'b0;

            if (w_in_bit) begin
                r_baud <= w_bit_end ? '0 : r_baud + c_BAUD_W'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        fifo_r_en <= 1'b1;
                        r_state   <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_state <= c_LATCH;
                end
                c_LATCH: begin
                    // FIFO data_out became valid on the FETCH edge
                    r_shift   <= fifo_data;
                    r_parity  <= (^fifo_data) ^ c_PAR_ODD;
                    tx        <= 1'b0;
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    r_state   <= c_START;
                end
                c_START: begin
                    if (w_bit_end) begin
                        tx      <= r_shift[0];
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx      <= r_parity;
                                r_state <= c_PARITY;
                            end else begin
                                tx      <= 1'b1;
                                r_state <= c_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                            tx        <= r_shift[1];
                        end
                    end
                end
                c_PARITY: begin
                    if (w_bit_end) begin
                        tx      <= 1'b1;
                        r_state <= c_STOP;
                    end
                end
                c_STOP: begin
                    // bit index is reused to count stop bits
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_bit_idx  <= '0;
                            r_state    <= c_IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// Bench: three UART transmitters (plain, even parity + 2 stop, odd parity),
// each fed by its own 8-deep synchronous FIFO, with a byte scoreboard.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       fifo_rst_n;
    logic       tx_en;
    logic [2:0] wr_en;
    logic [7:0] wr_data;

    logic [2:0]  tx_v;
    logic [2:0]  busy_v;
    logic [2:0]  ren_v;
    logic [2:0]  done_v;
    logic [2:0]  empty_v;
    logic [11:0] cnt_v;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ren_cnt0 = 0;
    int bad_ren0 = 0;

    logic [7:0] exp_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren_v[0] === 1'b1) ren_cnt0 <= ren_cnt0 + 1;
        if (ren_v[0] === 1'b1 && empty_v[0] === 1'b1) bad_ren0 <= bad_ren0 + 1;
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [7:0] mem [8];
        logic [2:0] wp;
        logic [2:0] rp;
        logic [3:0] cnt;
        logic [7:0] dout;
        logic       ren;
        logic       txo;
        logic       bsy;
        logic       dn;
        logic       emp;
        logic       do_w;
        logic       do_r;

        assign emp  = (cnt == 4'd0);
        assign do_w = wr_en[i] && (cnt != 4'd8);
        assign do_r = ren && (cnt != 4'd0);

        always @(posedge clk) begin
            if (!fifo_rst_n) begin
                wp   <= '0;
                rp   <= '0;
                cnt  <= '0;
                dout <= '0;
            end else begin
                if (do_w) begin
                    mem[wp] <= wr_data;
                    wp      <= wp + 3'd1;
                end
                if (do_r) begin
                    dout <= mem[rp];
                    rp   <= rp + 3'd1;
                end
                cnt <= cnt + {3'b0, do_w} - {3'b0, do_r};
            end
        end

        fifo_uart_tx #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(4),
            .STOP_BITS   ((i == 1) ? 2 : 1),
            .PARITY_EN   ((i > 0) ? 1 : 0),
            .PARITY_ODD  ((i == 2) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_en     (tx_en),
            .fifo_empty(emp),
            .fifo_data (dout),
            .fifo_r_en (ren),
            .tx        (txo),
            .busy      (bsy),
            .frame_done(dn)
        );

        assign tx_v[i]         = txo;
        assign busy_v[i]       = bsy;
        assign ren_v[i]        = ren;
        assign done_v[i]       = dn;
        assign empty_v[i]      = emp;
        assign cnt_v[4*i +: 4] = cnt;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        wr_data   = b;
        wr_en[ch] = 1'b1;
        exp_q[ch].push_back(b);
        @(posedge clk);
        #1;
        wr_en[ch] = 1'b0;
    endtask

    // Waits for a start bit, captures the whole frame at mid-cycle points and
    // checks it against a waveform rebuilt from the scoreboard byte.
    task automatic recv_frame(input int ch, input int stops, input bit pen, input bit podd,
                              output int t_start, output logic [63:0] wave, output int done_at);
        int         ncyc;
        int         nd;
        int         waited;
        int         b;
        logic [7:0] d;
        logic [7:0] e;
        logic [63:0] ew;
        ncyc    = (1 + 8 + int'(pen) + stops) * 4;
        wave    = '0;
        ew      = '0;
        done_at = -1;
        nd      = 0;
        t_start = -1;
        waited  = 0;
        @(negedge clk);
        while (tx_v[ch] !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (tx_v[ch] !== 1'b0) begin
            chk($sformatf("ch%0d_start_bit", ch), {63'b0, tx_v[ch]}, 64'd0);
            return;
        end
        t_start = cyc;
        for (int k = 0; k < ncyc + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (k < ncyc) wave[k] = tx_v[ch];
            if (done_v[ch] === 1'b1) begin
                nd++;
                if (done_at < 0) done_at = k;
            end
            if (k == ncyc) chk($sformatf("ch%0d_busy_after", ch), {63'b0, busy_v[ch]}, 64'd0);
        end
        for (int j = 0; j < 8; j++) d[j] = wave[4 * (1 + j) + 2];
        chk($sformatf("ch%0d_sb_nonempty", ch), {63'b0, exp_q[ch].size() != 0}, 64'd1);
        e = (exp_q[ch].size() != 0) ? exp_q[ch].pop_front() : 8'h00;
        chk($sformatf("ch%0d_data", ch), {56'b0, d}, {56'b0, e});
        for (int k = 0; k < ncyc; k++) begin
            b = k / 4;
            if (b == 0)                 ew[k] = 1'b0;
            else if (b <= 8)            ew[k] = e[b - 1];
            else if (b == 9 && pen)     ew[k] = (^e) ^ podd;
            else                        ew[k] = 1'b1;
        end
        chk($sformatf("ch%0d_wave", ch), wave, ew);
        chk($sformatf("ch%0d_done_count", ch), 64'(nd), 64'd1);
        chk($sformatf("ch%0d_done_at", ch), 64'(done_at), 64'(ncyc));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t1, t2, t3, c0, base, idle_ok, waited, dat;
        logic [63:0] w;
        logic [9:0]  p;

        rst_n      = 1'b0;
        fifo_rst_n = 1'b0;
        tx_en      = 1'b0;
        wr_en      = '0;
        wr_data    = '0;
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        fifo_rst_n = 1'b1;
        chk("reset_tx",   {63'b0, tx_v[0]},   64'd1);
        chk("reset_busy", {63'b0, busy_v[0]}, 64'd0);
        chk("reset_ren",  {63'b0, ren_v[0]},  64'd0);
        tx_en   = 1'b1;
        idle_ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_v[0] === 1'b1 && busy_v[0] === 1'b0 && ren_v[0] === 1'b0) idle_ok++;
        end
        chk("idle_50_cycles", 64'(idle_ok), 64'd50);

        // single word
        base = ren_cnt0;
        push(0, 8'hA5);
        recv_frame(0, 1, 1'b0, 1'b0, t1, w, dat);
        for (int k = 0; k < 10; k++) p[k] = w[4 * k + 2];
        chk("a5_pattern", {54'b0, p}, {54'b0, 10'b1101001010});
        chk("a5_ren_pulses", 64'(ren_cnt0 - base), 64'd1);

        // three words back to back
        base = ren_cnt0;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        recv_frame(0, 1, 1'b0, 1'b0, t1, w, dat);
        recv_frame(0, 1, 1'b0, 1'b0, t2, w, dat);
        recv_frame(0, 1, 1'b0, 1'b0, t3, w, dat);
        chk("b2b_gap_1", 64'(t2 - t1), 64'd43);
        chk("b2b_gap_2", 64'(t3 - t2), 64'd43);
        chk("b2b_ren_pulses", 64'(ren_cnt0 - base), 64'd3);
        chk("ren_while_empty", 64'(bad_ren0), 64'd0);

        // parity variants
        push(1, 8'h07);
        recv_frame(1, 2, 1'b1, 1'b0, t1, w, dat);
        chk("even_parity_bit", {63'b0, w[38]}, 64'd1);
        chk("two_stop_len", 64'(dat - 40), 64'd8);
        push(2, 8'h07);
        recv_frame(2, 1, 1'b1, 1'b1, t1, w, dat);
        chk("odd_parity_bit", {63'b0, w[38]}, 64'd0);

        // tx_en gating
        @(negedge clk);
        tx_en = 1'b0;
        base  = ren_cnt0;
        push(0, 8'h5A);
        push(0, 8'hC3);
        repeat (10) @(negedge clk);
        chk("gated_no_fetch", 64'(ren_cnt0 - base), 64'd0);
        chk("gated_idle",     {63'b0, busy_v[0]}, 64'd0);
        chk("gated_fifo_cnt", {60'b0, cnt_v[3:0]}, 64'd2);
        c0    = cyc;
        tx_en = 1'b1;
        fork
            begin
                repeat (12) @(negedge clk);
                tx_en = 1'b0;
            end
        join_none
        recv_frame(0, 1, 1'b0, 1'b0, t1, w, dat);
        chk("enable_latency", 64'(t1 - c0), 64'd3);
        repeat (10) @(negedge clk);
        chk("drop_en_one_fetch", 64'(ren_cnt0 - base), 64'd1);
        chk("drop_en_fifo_cnt",  {60'b0, cnt_v[3:0]}, 64'd1);
        chk("drop_en_idle",      {63'b0, busy_v[0]}, 64'd0);

        // reset during DATA aborts the frame; next word goes out intact
        push(0, 8'h96);
        @(negedge clk);
        tx_en  = 1'b1;
        waited = 0;
        while (tx_v[0] !== 1'b0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_frame_started", {63'b0, tx_v[0]}, 64'd0);
        repeat (4 + 4 * 2 + 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_tx",   {63'b0, tx_v[0]},   64'd1);
        chk("midreset_busy", {63'b0, busy_v[0]}, 64'd0);
        rst_n = 1'b1;
        if (exp_q[0].size() != 0) void'(exp_q[0].pop_front());
        recv_frame(0, 1, 1'b0, 1'b0, t1, w, dat);
        repeat (5) @(negedge clk);
        chk("final_fifo_empty", {63'b0, empty_v[0]}, 64'd1);
        chk("final_sb_empty",   64'(exp_q[0].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer for the team's synchronous FIFO. Pops one word at a time through the FIFO read port (r_en/empty/data_out, registered one-cycle read latency) and serializes each word onto an asynchronous UART line: start bit, data LSB-first, optional parity, then stop bit(s). Sits between the transmit FIFO and the chip pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the FIFO's DATA_WIDTH; legal range 5..9
CLKS_PER_BIT, 16, clk cycles per line bit; must be >= 2
STOP_BITS, 1, number of stop bits; 1 or 2
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
tx_en  input  1  1 allows new frames to start; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after the edge that samples fifo_r_en=1
fifo_r_en  output  1  FIFO read enable; registered; one-cycle pulse per word
tx  output  1  serial line; registered; idles high
busy  output  1  1 whenever state != IDLE
frame_done  output  1  one-cycle pulse on the edge the last stop bit completes

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, tx=1, fifo_r_en=0, frame_done=0, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts the frame; tx returns high at that edge. A word already popped is discarded.
- The clock and reset are fixed: one clock, clk; synchronous active-low reset, rst_n.
- States: IDLE, FETCH, LATCH, START, DATA, PARITY, STOP.
- IDLE: at an edge with tx_en=1 and fifo_empty=0, go to FETCH and set fifo_r_en<=1. Otherwise stay. fifo_r_en is never asserted while fifo_empty is sampled 1.
- FETCH: lasts exactly 1 cycle. fifo_r_en<=0, go to LATCH. The FIFO updates data_out on this edge.
- LATCH: lasts exactly 1 cycle. Shift register <= fifo_data, tx<=0, baud counter<=0, go to START.
- START, DATA, PARITY: each bit holds tx for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- DATA: sends shift register bit 0 first and shifts right. The bit index counts 0..DATA_WIDTH-1. After the last data bit, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx = XOR of the captured word, XOR PARITY_ODD.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final edge of STOP: state<=IDLE, frame_done<=1 for one cycle.
- Line frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles. Defaults give 160.
- Back-to-back frames: start-bit falling edges are exactly frame length + 3 cycles apart (IDLE sample, FETCH, LATCH). tx stays high during the gap.
- tx_en deasserted mid-frame: the current frame completes normally and no new fetch is made. fifo_empty and tx_en are ignored outside IDLE.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_WIDTH) bits. Neither counter exceeds its terminal value.

Test Plan:
- Bench setup: CLKS_PER_BIT=4, defaults otherwise, driving a real synchronous FIFO of DEPTH=8.
- Reset then idle: tx=1, busy=0, fifo_r_en=0 for 50 cycles while the FIFO is empty.
- Single word 0xA5: write it to the FIFO. Expect exactly one fifo_r_en pulse. tx pattern, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. frame_done pulses once; total 40 line cycles; busy returns to 0.
- Three words 0x00, 0xFF, 0x3C written back-to-back: all three decoded in order. Start bits are 43 cycles apart. Exactly 3 fifo_r_en pulses, and none while fifo_empty=1.
- PARITY_EN=1, PARITY_ODD=0 with 0x07: parity bit = 1. Then PARITY_ODD=1 with 0x07: parity bit = 0. STOP_BITS=2: the stop phase lasts 8 cycles.
- tx_en=0 with 2 words queued: no fetch. Raise tx_en: transmission starts 3 cycles later. Drop tx_en mid-frame: that frame completes and the second word stays in the FIFO.
- rst_n low for 1 cycle in the middle of DATA: tx=1 and busy=0 from the reset edge. The next queued word is then sent intact.
